// File: rtl/pipe_mux_sel.sv
// pipe_mux_sel: N-way, W-bit selector with a registered, valid/ready
// handshaked output held in a 2-entry skid buffer. An out-of-range select
// stores a zero word with its error bit set.
// Optional feature: define PIPE_MUX_SEL_ERRCNT_EN to add a saturating
// 16-bit err_count of accepted pushes with select >= NUM_IN.
module pipe_mux_sel #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        select,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
`ifdef PIPE_MUX_SEL_ERRCNT_EN
  ,
  output logic [15:0]             err_count
`endif
);

  // Buffer occupancy doubles as the control state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nxt_state;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_data0;   // head entry
  logic             r_err0;
  logic [WIDTH-1:0] r_data1;   // second entry
  logic             r_err1;

  logic [WIDTH-1:0] w_sel_word;
  logic             w_sel_err;
  logic             w_push;
  logic             w_pop;
  logic             w_load_head;
  logic             w_head_from_tail;
  logic             w_load_tail;

  // Select the addressed input; anything out of range leaves the word at zero.
  always_comb begin
    // NOTE: assigning a default before the loop keeps this purely
    // combinational; a path that leaves w_sel_word unassigned would infer a latch.
    w_sel_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (select == SEL_W'(i)) w_sel_word = data_in[i*WIDTH +: WIDTH];
    end
  end

  // With a power-of-two input count every select value is legal.
  if (NUM_IN == (1 << SEL_W)) begin : g_pow2
    assign w_sel_err = 1'b0;
  end else begin : g_range
    assign w_sel_err = (select >= SEL_W'(NUM_IN));
  end

  assign w_push = in_valid && r_in_ready;
  assign w_pop  = out_valid && out_ready;

  // Next occupancy and which entries load; flush overrides everything.
  always_comb begin
    w_nxt_state      = r_state;
    w_load_head      = 1'b0;
    w_head_from_tail = 1'b0;
    w_load_tail      = 1'b0;
    if (flush) begin
      w_nxt_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_nxt_state = ST_ONE;
            w_load_head = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_load_head = 1'b1;
          end else if (w_push) begin
            w_nxt_state = ST_FULL;
            w_load_tail = 1'b1;
          end else if (w_pop) begin
            w_nxt_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so no push can coincide with the pop.
          if (w_pop) begin
            w_nxt_state      = ST_ONE;
            w_head_from_tail = 1'b1;
          end
        end
        default: w_nxt_state = ST_EMPTY;
      endcase
    end
  end

  // State register; in_ready is precomputed so it never depends on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of block ordering.
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_in_ready <= (w_nxt_state != ST_FULL);
    end
  end

  // Entry storage: load head from input or promote the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only two entries, so they are cleared on reset like any other
      // register; a deep buffer would normally be left unreset.
      r_data0 <= '0;
      r_err0  <= 1'b0;
      r_data1 <= '0;
      r_err1  <= 1'b0;
    end else begin
      if (w_load_head) begin
        r_data0 <= w_sel_word;
        r_err0  <= w_sel_err;
      end else if (w_head_from_tail) begin
        r_data0 <= r_data1;
        r_err0  <= r_err1;
      end
      if (w_load_tail) begin
        r_data1 <= w_sel_word;
        r_err1  <= w_sel_err;
      end
    end
  end

  // Outputs are gated to zero whenever the buffer is empty.
  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = out_valid ? r_data0 : '0;
  assign sel_err   = out_valid && r_err0;

`ifdef PIPE_MUX_SEL_ERRCNT_EN
  logic [15:0] r_err_count;

  // Saturating count of accepted out-of-range pushes; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (!flush && w_push && w_sel_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_pipe_mux_sel.sv
// Self-checking bench for pipe_mux_sel: a table of per-cycle vectors for the
// 4-input instance, plus hand-written flush, reset and out-of-range sequences
// (the last on a 3-input instance).
module tb_pipe_mux_sel;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-input, 32-bit instance
  logic [127:0] data_in;
  logic [1:0]   select;
  logic         in_valid, in_ready, flush, out_valid, out_ready, sel_err;
  logic [31:0]  out_data;

  // 3-input, 8-bit instance
  logic [23:0]  data_in3;
  logic [1:0]   select3;
  logic         in_valid3, in_ready3, flush3, out_valid3, out_ready3, sel_err3;
  logic [7:0]   out_data3;

`ifdef PIPE_MUX_SEL_ERRCNT_EN
  logic [15:0]  err_count, err_count3;
`endif

  pipe_mux_sel #(.WIDTH(32), .NUM_IN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .select(select),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err)
`ifdef PIPE_MUX_SEL_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  pipe_mux_sel #(.WIDTH(8), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in3), .select(select3),
    .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .sel_err(sel_err3)
`ifdef PIPE_MUX_SEL_ERRCNT_EN
    , .err_count(err_count3)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One record per clock: inputs applied before the edge, outputs expected after it.
  typedef struct {
    logic             vld;
    logic [1:0]       sel;
    logic [3:0][31:0] d;
    logic             ordy;
    logic             e_ov;
    logic [31:0]      e_od;
    logic             e_err;
    logic             e_ir;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  task automatic set_row(input int idx, input logic vld, input logic [1:0] sel,
                         input logic [3:0][31:0] d, input logic ordy,
                         input logic e_ov, input logic [31:0] e_od, input logic e_ir);
    tbl[idx].vld   = vld;
    tbl[idx].sel   = sel;
    tbl[idx].d     = d;
    tbl[idx].ordy  = ordy;
    tbl[idx].e_ov  = e_ov;
    tbl[idx].e_od  = e_od;
    tbl[idx].e_err = 1'b0;
    tbl[idx].e_ir  = e_ir;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_main(input logic [31:0] word, input logic ordy);
    in_valid  = 1'b1;
    select    = 2'd0;
    data_in   = {96'h0, word};
    out_ready = ordy;
    step();
  endtask

  task automatic check_main(input string tag, input logic ov, input logic [31:0] od, input logic ir);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".out_data"},  out_data,       od);
    check({tag, ".sel_err"},   32'(sel_err),   32'h0);
    check({tag, ".in_ready"},  32'(in_ready),  32'(ir));
  endtask

  initial begin
    logic [3:0][31:0] d;

    // ---- vector table ----
    d = {32'h44, 32'h33, 32'h22, 32'h11};
    set_row(0, 1'b1, 2'd2, d, 1'b1, 1'b1, 32'h33, 1'b1);     // latency 1
    set_row(1, 1'b0, 2'd0, d, 1'b1, 1'b0, 32'h0,  1'b1);     // drained, gated
    d = {32'h0, 32'h0, 32'hB, 32'hA};
    set_row(2, 1'b1, 2'd0, d, 1'b0, 1'b1, 32'hA, 1'b1);      // push A, stalled
    set_row(3, 1'b1, 2'd1, d, 1'b0, 1'b1, 32'hA, 1'b0);      // push B -> FULL
    d = {32'h0, 32'h0, 32'h0, 32'hC};
    set_row(4, 1'b1, 2'd0, d, 1'b0, 1'b1, 32'hA, 1'b0);      // refused push
    set_row(5, 1'b0, 2'd0, d, 1'b1, 1'b1, 32'hB, 1'b1);      // A taken, B head
    set_row(6, 1'b0, 2'd0, d, 1'b1, 1'b0, 32'h0, 1'b1);      // B taken
    for (int r = 0; r < 8; r++) begin                         // streaming
      logic [3:0][31:0] sd;
      for (int j = 0; j < 4; j++) sd[j] = 32'h100 + 32'(r * 16 + j);
      set_row(7 + r, 1'b1, 2'(r % 4), sd, 1'b1, 1'b1, sd[r % 4], 1'b1);
    end
    set_row(15, 1'b0, 2'd0, d, 1'b1, 1'b0, 32'h0, 1'b1);

    // ---- reset ----
    rst_n = 1'b0;
    data_in = '0; select = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    data_in3 = '0; select3 = '0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_main("reset", 1'b0, 32'h0, 1'b0);
    check("reset.in_ready3", 32'(in_ready3), 32'h0);
    rst_n = 1'b1;
    step();
    check_main("post_reset", 1'b0, 32'h0, 1'b1);

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      in_valid  = tbl[i].vld;
      select    = tbl[i].sel;
      data_in   = tbl[i].d;
      out_ready = tbl[i].ordy;
      step();
      check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      check($sformatf("vec%0d.out_data", i),  out_data,       tbl[i].e_od);
      check($sformatf("vec%0d.sel_err", i),   32'(sel_err),   32'(tbl[i].e_err));
      check($sformatf("vec%0d.in_ready", i),  32'(in_ready),  32'(tbl[i].e_ir));
    end

    // ---- flush while FULL with a concurrent in_valid ----
    push_main(32'hD1, 1'b0);
    push_main(32'hD2, 1'b0);
    check_main("flush_full.pre", 1'b1, 32'hD1, 1'b0);
    flush = 1'b1;
    push_main(32'hD3, 1'b1);
    flush = 1'b0;
    check_main("flush_full.edge", 1'b0, 32'h0, 1'b1);
    in_valid = 1'b0;
    step();
    check_main("flush_full.after", 1'b0, 32'h0, 1'b1);

    // ---- flush from ONE: accepted handshake is discarded ----
    push_main(32'hE1, 1'b0);
    flush = 1'b1;
    push_main(32'hE2, 1'b0);
    flush = 1'b0;
    check_main("flush_one.edge", 1'b0, 32'h0, 1'b1);
    in_valid = 1'b0;
    step();
    check_main("flush_one.after", 1'b0, 32'h0, 1'b1);

    // ---- reset mid-transfer while FULL ----
    push_main(32'hF1, 1'b0);
    push_main(32'hF2, 1'b0);
    check_main("midrst.full", 1'b1, 32'hF1, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_main("midrst.async", 1'b0, 32'h0, 1'b0);
    #2 rst_n = 1'b1;
    step();
    check_main("midrst.release", 1'b0, 32'h0, 1'b1);
    in_valid  = 1'b1;
    select    = 2'd3;
    data_in   = {32'hF3, 96'h0};
    out_ready = 1'b1;
    step();
    check_main("midrst.first_push", 1'b1, 32'hF3, 1'b1);
    in_valid = 1'b0;
    step();
    check_main("midrst.drained", 1'b0, 32'h0, 1'b1);

    // ---- out-of-range select on the 3-input instance ----
    data_in3   = {8'h33, 8'h22, 8'h11};
    in_valid3  = 1'b1;
    select3    = 2'd3;
    out_ready3 = 1'b0;
    step();
    check("oor.out_valid", 32'(out_valid3), 32'h1);
    check("oor.out_data",  32'(out_data3),  32'h0);
    check("oor.sel_err",   32'(sel_err3),   32'h1);
    select3 = 2'd2;
    step();
    check("oor.hold_data", 32'(out_data3), 32'h0);
    check("oor.hold_err",  32'(sel_err3),  32'h1);
    check("oor.full",      32'(in_ready3), 32'h0);
    in_valid3  = 1'b0;
    out_ready3 = 1'b1;
    step();
    check("oor.next_data", 32'(out_data3), 32'h33);
    check("oor.next_err",  32'(sel_err3),  32'h0);
    step();
    check("oor.empty_valid", 32'(out_valid3), 32'h0);
    check("oor.empty_err",   32'(sel_err3),   32'h0);
`ifdef PIPE_MUX_SEL_ERRCNT_EN
    check("errcnt3", 32'(err_count3), 32'h1);
    check("errcnt4", 32'(err_count),  32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
